// File: rtl/pulse_src_gen_pkg.sv
// Shared types and constants for the multi-channel pulse source.
// Register map, reset values and the per-channel state encoding.
package pulse_src_gen_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DELAY = 3'd1,
    ST_RISE  = 3'd2,
    ST_HIGH  = 3'd3,
    ST_FALL  = 3'd4,
    ST_LOW   = 3'd5,
    ST_DONE  = 3'd6
  } pulse_state_e;

  localparam logic [3:0] ADDR_IV   = 4'd0;
  localparam logic [3:0] ADDR_PV   = 4'd1;
  localparam logic [3:0] ADDR_TD   = 4'd2;
  localparam logic [3:0] ADDR_TR   = 4'd3;
  localparam logic [3:0] ADDR_TH   = 4'd4;
  localparam logic [3:0] ADDR_TF   = 4'd5;
  localparam logic [3:0] ADDR_TL   = 4'd6;
  localparam logic [3:0] ADDR_NPER = 4'd7;
  localparam logic [3:0] ADDR_SR   = 4'd8;
  localparam logic [3:0] ADDR_SF   = 4'd9;

  localparam int RST_IV   = 0;
  localparam int RST_PV   = 0;
  localparam int RST_TD   = 0;
  localparam int RST_TR   = 1;
  localparam int RST_TH   = 1;
  localparam int RST_TF   = 1;
  localparam int RST_TL   = 1;
  localparam int RST_NPER = 0;
  localparam int RST_SR   = 1;
  localparam int RST_SF   = 1;

endpackage

// File: rtl/pulse_src_gen_ch.sv
// One pulse channel: config registers, phase FSM, counters and edge ramp.
// PULSE_SRC_GEN_RAMP_EN enables SR/SF stepping on the edges.
module pulse_src_gen_ch
  import pulse_src_gen_pkg::*;
#(
  parameter int WIDTH = 12,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [3:0]       wr_addr,
  input  logic [CNT_W-1:0] wr_data,
  input  logic             start,
  input  logic             stop,
  output logic [WIDTH-1:0] out_val,
  output logic             busy,
  output logic             done
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  pulse_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, per_q, per_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             busy_q, busy_d, done_q, done_d;

  logic [WIDTH-1:0] iv_q, iv_d, pv_q, pv_d;
  logic [CNT_W-1:0] td_q, td_d, tr_q, tr_d, th_q, th_d;
  logic [CNT_W-1:0] tf_q, tf_d, tl_q, tl_d, nper_q, nper_d;

  logic [CNT_W-1:0] len_s, cnt_inc_s, per_inc_s;
  logic             last_s, near_s;
  logic [WIDTH-1:0] rise_first_step_s, rise_next_s, fall_first_step_s, fall_next_s;
  logic [WIDTH-1:0] rise_first_s, fall_first_s;

  function automatic logic [CNT_W-1:0] max1(input logic [CNT_W-1:0] d);
    return (d == '0) ? ONE : d;
  endfunction

`ifdef PULSE_SRC_GEN_RAMP_EN
  logic [WIDTH-1:0] sr_q, sr_d, sf_q, sf_d;

  // One ramp step from cur toward target, saturating at target in either direction.
  function automatic logic [WIDTH-1:0] ramp_step(input logic [WIDTH-1:0] cur,
                                                 input logic [WIDTH-1:0] step,
                                                 input logic [WIDTH-1:0] target);
    logic [WIDTH:0]   acc;
    logic [WIDTH-1:0] res;
    if (target >= cur) begin
      acc = {1'b0, cur} + {1'b0, step};
      res = (acc >= {1'b0, target}) ? target : acc[WIDTH-1:0];
    end else begin
      acc = {1'b0, cur} - {1'b0, step};
      res = (acc[WIDTH] || (acc[WIDTH-1:0] <= target)) ? target : acc[WIDTH-1:0];
    end
    return res;
  endfunction

  assign rise_first_step_s = ramp_step(iv_q, sr_q, pv_q);
  assign rise_next_s       = ramp_step(out_q, sr_q, pv_q);
  assign fall_first_step_s = ramp_step(pv_q, sf_q, iv_q);
  assign fall_next_s       = ramp_step(out_q, sf_q, iv_q);
`else
  assign rise_first_step_s = iv_q;
  assign rise_next_s       = iv_q;
  assign fall_first_step_s = pv_q;
  assign fall_next_s       = pv_q;
`endif

  assign rise_first_s = (max1(tr_q) == ONE) ? pv_q : rise_first_step_s;
  assign fall_first_s = (max1(tf_q) == ONE) ? iv_q : fall_first_step_s;
  assign cnt_inc_s    = cnt_q + ONE;
  assign per_inc_s    = per_q + ONE;

  // Register write decode.
  always_comb begin
    iv_d   = iv_q;
    pv_d   = pv_q;
    td_d   = td_q;
    tr_d   = tr_q;
    th_d   = th_q;
    tf_d   = tf_q;
    tl_d   = tl_q;
    nper_d = nper_q;
`ifdef PULSE_SRC_GEN_RAMP_EN
    sr_d   = sr_q;
    sf_d   = sf_q;
`endif
    case ({wr_en, wr_addr})
      {1'b1, ADDR_IV}:   iv_d   = wr_data[WIDTH-1:0];
      {1'b1, ADDR_PV}:   pv_d   = wr_data[WIDTH-1:0];
      {1'b1, ADDR_TD}:   td_d   = wr_data;
      {1'b1, ADDR_TR}:   tr_d   = wr_data;
      {1'b1, ADDR_TH}:   th_d   = wr_data;
      {1'b1, ADDR_TF}:   tf_d   = wr_data;
      {1'b1, ADDR_TL}:   tl_d   = wr_data;
      {1'b1, ADDR_NPER}: nper_d = wr_data;
`ifdef PULSE_SRC_GEN_RAMP_EN
      {1'b1, ADDR_SR}:   sr_d   = wr_data[WIDTH-1:0];
      {1'b1, ADDR_SF}:   sf_d   = wr_data[WIDTH-1:0];
`endif
      default: ;
    endcase
  end

  // Duration of the current phase and end-of-phase flags.
  always_comb begin
    case (state_q)
      ST_DELAY: len_s = td_q;
      ST_RISE:  len_s = max1(tr_q);
      ST_HIGH:  len_s = max1(th_q);
      ST_FALL:  len_s = max1(tf_q);
      ST_LOW:   len_s = max1(tl_q);
      default:  len_s = ONE;
    endcase
    last_s = (cnt_q >= len_s);
    near_s = (cnt_inc_s >= len_s);
  end

  // Phase sequencing; the output code for the coming cycle is computed alongside.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    per_d   = per_q;
    out_d   = out_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        out_d = iv_d;
        if (start) begin
          per_d = '0;
          cnt_d = ONE;
          if (td_q == '0) begin
            state_d = ST_RISE;
            out_d   = rise_first_s;
          end else begin
            state_d = ST_DELAY;
            out_d   = iv_q;
          end
        end else begin
          state_d = state_q;
        end
      end
      ST_DELAY: begin
        if (last_s) begin
          state_d = ST_RISE;
          cnt_d   = ONE;
          out_d   = rise_first_s;
        end else begin
          cnt_d = cnt_inc_s;
          out_d = iv_q;
        end
      end
      ST_RISE: begin
        if (last_s) begin
          state_d = ST_HIGH;
          cnt_d   = ONE;
          out_d   = pv_q;
        end else begin
          cnt_d = cnt_inc_s;
          out_d = near_s ? pv_q : rise_next_s;
        end
      end
      ST_HIGH: begin
        if (last_s) begin
          state_d = ST_FALL;
          cnt_d   = ONE;
          out_d   = fall_first_s;
        end else begin
          cnt_d = cnt_inc_s;
          out_d = pv_q;
        end
      end
      ST_FALL: begin
        if (last_s) begin
          state_d = ST_LOW;
          cnt_d   = ONE;
          out_d   = iv_q;
        end else begin
          cnt_d = cnt_inc_s;
          out_d = near_s ? iv_q : fall_next_s;
        end
      end
      ST_LOW: begin
        if (last_s) begin
          per_d = per_inc_s;
          cnt_d = ONE;
          if ((nper_q != '0) && (per_inc_s == nper_q)) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            out_d   = iv_q;
          end else begin
            state_d = ST_RISE;
            out_d   = rise_first_s;
          end
        end else begin
          cnt_d = cnt_inc_s;
          out_d = iv_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        out_d   = iv_q;
      end
    endcase
    if (stop) begin
      state_d = ST_IDLE;
      out_d   = iv_d;
      done_d  = 1'b0;
    end else begin
      done_d = done_d;
    end
    busy_d = (state_d != ST_IDLE) && (state_d != ST_DONE);
  end

  // State, counters, outputs and config registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= ONE;
      per_q   <= '0;
      out_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      iv_q    <= WIDTH'(RST_IV);
      pv_q    <= WIDTH'(RST_PV);
      td_q    <= CNT_W'(RST_TD);
      tr_q    <= CNT_W'(RST_TR);
      th_q    <= CNT_W'(RST_TH);
      tf_q    <= CNT_W'(RST_TF);
      tl_q    <= CNT_W'(RST_TL);
      nper_q  <= CNT_W'(RST_NPER);
`ifdef PULSE_SRC_GEN_RAMP_EN
      sr_q    <= WIDTH'(RST_SR);
      sf_q    <= WIDTH'(RST_SF);
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      per_q   <= per_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      iv_q    <= iv_d;
      pv_q    <= pv_d;
      td_q    <= td_d;
      tr_q    <= tr_d;
      th_q    <= th_d;
      tf_q    <= tf_d;
      tl_q    <= tl_d;
      nper_q  <= nper_d;
`ifdef PULSE_SRC_GEN_RAMP_EN
      sr_q    <= sr_d;
      sf_q    <= sf_d;
`endif
    end
  end

  assign out_val = out_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: rtl/pulse_src_gen.sv
// N-channel pulse/rect source: config routing, cfg_ready mux, channel array.
// Optional edge ramps are enabled by defining PULSE_SRC_GEN_RAMP_EN.
module pulse_src_gen
  import pulse_src_gen_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int WIDTH = 12,
  parameter int CNT_W = 16,
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [CH_W-1:0]       cfg_ch,
  input  logic [3:0]            cfg_addr,
  input  logic [CNT_W-1:0]      cfg_data,
  input  logic [N_CH-1:0]       start,
  input  logic [N_CH-1:0]       stop,
  output logic [N_CH*WIDTH-1:0] out_val,
  output logic [N_CH-1:0]       busy,
  output logic [N_CH-1:0]       done
);

  logic            ready_s;
  logic [N_CH-1:0] wr_en_s;

  // A write stalls only while its target channel is running; unmapped indices accept and drop.
  always_comb begin
    ready_s = 1'b1;
    for (int c = 0; c < N_CH; c++) begin
      if (cfg_ch == CH_W'(c)) begin
        ready_s = ~busy[c];
      end else begin
        ready_s = ready_s;
      end
    end
  end

  assign cfg_ready = ready_s;

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    assign wr_en_s[c] = cfg_valid & ready_s & (cfg_ch == CH_W'(c));

    pulse_src_gen_ch #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_en_s[c]),
      .wr_addr (cfg_addr),
      .wr_data (cfg_data),
      .start   (start[c]),
      .stop    (stop[c]),
      .out_val (out_val[c*WIDTH +: WIDTH]),
      .busy    (busy[c]),
      .done    (done[c])
    );
  end

endmodule

// File: doc/pulse_src_gen.md
# pulse_src_gen

Multi-channel clocked pulse/rectangular waveform source for the digital-behavioural side of the simulator device library. It generalises the single-shot pulse and periodic rect sources to N independent channels. Each channel has a programmable delay, rise, high, fall and low phases, an optional linear edge ramp, and a period count (finite or continuous). Outputs are unsigned amplitude codes intended to drive DAC-style behavioural models or mixed-signal testbenches.

## Interface
Parameters:
- N_CH, 4, number of independent channels (1..16)
- WIDTH, 12, amplitude code width
- CNT_W, 16, timing-counter and config-data width; WIDTH <= CNT_W

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous active-high reset
- cfg_valid  in  1  config write request
- cfg_ready  out  1  write accepted when valid&ready; = !busy[cfg_ch]
- cfg_ch  in  $clog2(N_CH)  target channel
- cfg_addr  in  4  register select
- cfg_data  in  CNT_W  write data (amplitude regs use low WIDTH bits)
- start  in  N_CH  per-channel start pulse
- stop  in  N_CH  per-channel abort
- out_val  out  N_CH*WIDTH  channel c at [c*WIDTH +: WIDTH]
- busy  out  N_CH  channel not IDLE/DONE
- done  out  N_CH  one-cycle pulse on finite-count completion

## Operation
- Registers per channel (reset value): 0 IV (0), 1 PV (0), 2 TD (0), 3 TR (1), 4 TH (1), 5 TF (1), 6 TL (1), 7 NPER (0 = continuous), 8 SR rise step (1), 9 SF fall step (1); addr 10..15 write-ignored, still handshake.
- States: IDLE, DELAY, RISE, HIGH, FALL, LOW, DONE.
- IDLE/DONE: out = IV. start -> DELAY, or RISE if TD=0; period counter cleared.
- Phase of duration D lasts max(D,1) cycles; TD=0 alone skips DELAY.
- RISE -> HIGH -> FALL -> LOW; LOW end: period count +1; if NPER!=0 and count==NPER -> DONE (done pulse), else -> RISE.
- HIGH: out = PV. LOW: out = IV. Last RISE cycle forces out=PV; last FALL cycle forces out=IV.
- Ramp arithmetic: WIDTH+1-bit add/sub, clamped at PV (rise) / IV (fall); PV<IV permitted, ramp direction follows sign.
- stop (any state) -> IDLE next cycle, out = IV. stop and start same cycle: stop wins.
- start while busy ignored. Config writes to busy channel stalled by cfg_ready.

## Timing
- All outputs registered. start at edge k -> state change visible at k+1; with TD=0 first RISE value at k+1.
- Period length = max(TR,1)+max(TH,1)+max(TF,1)+max(TL,1) cycles.
- done asserts in the first DONE cycle, busy deasserts same cycle.
- Reset: all channels IDLE, registers to reset values, out_val=0, busy=0, done=0; rst mid-waveform overrides everything in that cycle.
- Config write lands at edge of handshake; usable by start on the following cycle.

## Configuration
- PULSE_SRC_GEN_RAMP_EN defined: RISE/FALL step by SR/SF as above.
- Undefined: SR/SF regs absent (addr 8/9 write-ignored); out holds IV through RISE and PV through FALL, switching on the phase's last cycle (edge durations still timed).

## Structure
- Package pulse_src_gen_pkg: state enum, register address constants, register reset values.
- Sub-module pulse_src_gen_ch: one channel (registers, FSM, counters, ramp); top instantiates N_CH copies plus config decode and cfg_ready mux.

## Test plan
- Reset defaults: rst 1 cycle, start ch0 -> out toggles IV=0/PV=0, period 4 cycles, busy=1 continuously.
- One-shot: ch1 IV=100, PV=900, TD=3, TR=TH=TF=TL=2, NPER=1, start -> 3 cycles at 100, ramp, 2 at 900, fall, 2 at 100, done pulse at cycle 12, busy=0.
- Ramp clamp (RAMP_EN): IV=0, PV=10, SR=4, TR=5 -> RISE values 4,8,10,10,10; SF=3, TF=2 -> 7,0.
- Inverted ramp: IV=500, PV=100, SR=150 -> 350,200,100 clamped.
- Abort: stop mid-HIGH -> IDLE, out=IV next cycle; simultaneous start+stop -> stays IDLE.
- Handshake: write to busy channel -> cfg_ready=0 until stopped; writes to idle channel accepted in same cycle; rst mid-run -> all out 0.
